dec_tree_engine: RTL and testbench

- Parametrised successor to the single-tree DEC accelerator. Same four-mode host load protocol: feature index, threshold, children, data.
- Generalised in feature count and width, node count and class width. Adds multi-class leaves, output backpressure and a traversal depth guard with an error flag.
- Sits between the host input stage and the result collector. Processes one sample at a time with one tree node evaluated per cycle.

---
 rtl/dec_pkg.sv | 36 +++
 rtl/dec_node_mem.sv | 72 +++++++
 rtl/dec_tree_engine.sv | 162 ++++++++++++++++
 tb/tb_dec_tree_engine.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
//------------------------------------------------------------------------------
// dec_pkg : shared encodings and helpers for the decision-tree engine
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dec_pkg;

  localparam logic [1:0] MODE_FEA   = 2'b00;
  localparam logic [1:0] MODE_THR   = 2'b01;
  localparam logic [1:0] MODE_CHILD = 2'b10;
  localparam logic [1:0] MODE_DATA  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    EMIT = 2'd2
  } state_e;

  // The leaf flag is the MSB of a child word.
  function automatic int leaf_bit(input int feat_w);
    return feat_w - 1;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dec_node_mem.sv
//------------------------------------------------------------------------------
// dec_node_mem : feature-index, threshold and child tables with host write port
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dec_node_mem
  import dec_pkg::*;
#(
  parameter int FEAT_W   = 8,
  parameter int NUM_NODE = 11,
  parameter int NODE_AW  = 4,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [1:0]        mode_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [FEAT_W-1:0] param_i,
  input  logic [NODE_AW-1:0] node_i,
  input  logic [ADDR_W-1:0] slot_i,
  output logic [FEAT_W-1:0] fea_o,
  output logic [FEAT_W-1:0] thr_o,
  output logic [FEAT_W-1:0] child_o
);

  logic [FEAT_W-1:0] fea_q   [NUM_NODE];
  logic [FEAT_W-1:0] thr_q   [NUM_NODE];
  logic [FEAT_W-1:0] child_q [2*NUM_NODE];

  // Address decode by compare: out-of-range writes simply match no entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NODE; i++) begin
        fea_q[i] <= '0;
        thr_q[i] <= '0;
      end
      for (int i = 0; i < 2*NUM_NODE; i++) begin
        child_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int i = 0; i < NUM_NODE; i++) begin
        if (addr_i == ADDR_W'(i)) begin
          if (mode_i == MODE_FEA) fea_q[i] <= param_i;
          if (mode_i == MODE_THR) thr_q[i] <= param_i;
        end
      end
      for (int i = 0; i < 2*NUM_NODE; i++) begin
        if (mode_i == MODE_CHILD && addr_i == ADDR_W'(i)) child_q[i] <= param_i;
      end
    end
  end

  always_comb begin
    fea_o   = '0;
    thr_o   = '0;
    child_o = '0;
    for (int i = 0; i < NUM_NODE; i++) begin
      if (node_i == NODE_AW'(i)) begin
        fea_o = fea_q[i];
        thr_o = thr_q[i];
      end
    end
    for (int i = 0; i < 2*NUM_NODE; i++) begin
      if (slot_i == ADDR_W'(i)) child_o = child_q[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dec_tree_engine.sv
//------------------------------------------------------------------------------
// dec_tree_engine : one-node-per-cycle decision-tree traversal with depth guard
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dec_tree_engine
  import dec_pkg::*;
#(
  parameter int NUM_FEATURE = 8,
  parameter int FEAT_W      = 8,
  parameter int NUM_NODE    = 11,
  parameter int CLASS_W     = 1,
  parameter int ID_W        = 12,
  parameter int MAX_DEPTH   = 16,
  localparam int NODE_AW    = clog2(NUM_NODE),
  localparam int ADDR_W     = clog2(2*NUM_NODE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_mode,
  input  logic [ADDR_W-1:0]             in_addr,
  input  logic [FEAT_W-1:0]             in_param,
  input  logic [NUM_FEATURE*FEAT_W-1:0] in_data,
  input  logic [ID_W-1:0]               in_id,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ID_W-1:0]               out_id,
  output logic [CLASS_W-1:0]            out_class,
  output logic                          out_err
);

  localparam int DEPTH_W  = clog2(MAX_DEPTH + 1);
  localparam int LEAF_BIT = leaf_bit(FEAT_W);

  state_e                          state_q, state_d;
  logic [NODE_AW-1:0]              node_q, node_d;
  logic [DEPTH_W-1:0]              depth_q, depth_d;
  logic [NUM_FEATURE*FEAT_W-1:0]   data_q;
  logic [ID_W-1:0]                 id_q;
  logic                            valid_q, valid_d;
  logic [CLASS_W-1:0]              class_q, class_d;
  logic                            err_q, err_d;

  logic                            xfer_w;
  logic [FEAT_W-1:0]               fea_w, thr_w, child_w, x_w;
  logic                            gt_w;
  logic [ADDR_W-1:0]               slot_w;

  assign in_ready = (state_q == IDLE);
  assign xfer_w   = in_valid && in_ready;

  dec_node_mem #(
    .FEAT_W   (FEAT_W),
    .NUM_NODE (NUM_NODE),
    .NODE_AW  (NODE_AW),
    .ADDR_W   (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (xfer_w && (in_mode != MODE_DATA)),
    .mode_i  (in_mode),
    .addr_i  (in_addr),
    .param_i (in_param),
    .node_i  (node_q),
    .slot_i  (slot_w),
    .fea_o   (fea_w),
    .thr_o   (thr_w),
    .child_o (child_w)
  );

  always_comb begin
    x_w = '0;
    for (int f = 0; f < NUM_FEATURE; f++) begin
      if (fea_w == FEAT_W'(f)) x_w = data_q[f*FEAT_W +: FEAT_W];
    end
  end

  assign gt_w   = (x_w > thr_w);
  assign slot_w = {node_q, gt_w};

  always_comb begin
    state_d = state_q;
    node_d  = node_q;
    depth_d = depth_q;
    valid_d = valid_q;
    class_d = class_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (xfer_w && in_mode == MODE_DATA) begin
          state_d = WALK;
          node_d  = '0;
          depth_d = '0;
        end
      end
      WALK: begin
        if (int'(fea_w) >= NUM_FEATURE) begin
          state_d = EMIT;
          class_d = '0;
          err_d   = 1'b1;
        end else if (child_w[LEAF_BIT]) begin
          state_d = EMIT;
          class_d = child_w[CLASS_W-1:0];
          err_d   = 1'b0;
        end else if (int'(child_w[NODE_AW-1:0]) >= NUM_NODE ||
                     depth_q == DEPTH_W'(MAX_DEPTH - 1)) begin
          state_d = EMIT;
          class_d = '0;
          err_d   = 1'b1;
        end else begin
          node_d  = child_w[NODE_AW-1:0];
          depth_d = depth_q + 1'b1;
        end
      end
      EMIT: begin
        // Result flops are loaded on EMIT entry; valid follows one cycle later.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      node_q  <= '0;
      depth_q <= '0;
      data_q  <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      node_q  <= node_d;
      depth_q <= depth_d;
      valid_q <= valid_d;
      class_q <= class_d;
      err_q   <= err_d;
      if (xfer_w && in_mode == MODE_DATA) begin
        data_q <= in_data;
        id_q   <= in_id;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_id    = id_q;
  assign out_class = class_q;
  assign out_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dec_tree_engine.sv
// Self-checking bench for dec_tree_engine: directed scenarios plus random trees vs. a traversal model.
`default_nettype none

module tb_dec_tree_engine;

  localparam int NF  = 8;
  localparam int FW  = 8;
  localparam int NN  = 11;
  localparam int IDW = 12;
  localparam int MD  = 16;
  localparam int AW  = 5;
  localparam int DW  = NF*FW;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready, in_ready3;
  logic [1:0]     in_mode;
  logic [AW-1:0]  in_addr;
  logic [FW-1:0]  in_param;
  logic [DW-1:0]  in_data;
  logic [IDW-1:0] in_id;
  logic           out_valid, out_valid3;
  logic           out_ready;
  logic [IDW-1:0] out_id, out_id3;
  logic [0:0]     out_class;
  logic [2:0]     out_class3;
  logic           out_err, out_err3;

  int cmp_count = 0;
  int fail_count = 0;

  logic [FW-1:0] m_fea   [NN];
  logic [FW-1:0] m_thr   [NN];
  logic [FW-1:0] m_child [2*NN];

  always #5 clk = ~clk;

  dec_tree_engine #(.NUM_FEATURE(NF), .FEAT_W(FW), .NUM_NODE(NN), .CLASS_W(1),
                    .ID_W(IDW), .MAX_DEPTH(MD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_addr(in_addr), .in_param(in_param),
    .in_data(in_data), .in_id(in_id), .out_valid(out_valid),
    .out_ready(out_ready), .out_id(out_id), .out_class(out_class),
    .out_err(out_err));

  dec_tree_engine #(.NUM_FEATURE(NF), .FEAT_W(FW), .NUM_NODE(NN), .CLASS_W(3),
                    .ID_W(IDW), .MAX_DEPTH(MD)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in_mode(in_mode), .in_addr(in_addr), .in_param(in_param),
    .in_data(in_data), .in_id(in_id), .out_valid(out_valid3),
    .out_ready(out_ready), .out_id(out_id3), .out_class(out_class3),
    .out_err(out_err3));

  // Reference traversal: walk the tree as described, counting node evaluations.
  task automatic model(input logic [DW-1:0] d, output logic [2:0] cls,
                       output logic err, output int k);
    int node;
    logic [FW-1:0] x, c;
    node = 0; cls = 3'd0; err = 1'b0; k = 0;
    for (int step = 1; step <= MD; step++) begin
      k = step;
      if (m_fea[node] >= NF) begin err = 1'b1; return; end
      x = d[m_fea[node]*FW +: FW];
      c = (x <= m_thr[node]) ? m_child[2*node] : m_child[2*node+1];
      if (c[7]) begin cls = c[2:0]; return; end
      if (c[3:0] >= NN || step == MD) begin err = 1'b1; return; end
      node = c[3:0];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = 2'b00; in_addr = '0; in_param = '0; in_data = '0; in_id = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NN; i++) begin m_fea[i] = '0; m_thr[i] = '0; end
    for (int i = 0; i < 2*NN; i++) m_child[i] = '0;
  endtask

  task automatic host_xfer(input logic [1:0] mode, input logic [AW-1:0] addr,
                           input logic [FW-1:0] p, input logic [DW-1:0] d,
                           input logic [IDW-1:0] id);
    int n;
    in_mode = mode; in_addr = addr; in_param = p; in_data = d; in_id = id;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      cmp_count++; fail_count++;
      $display("FAIL host_accept: in_ready=%b never rose within 200 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic write_word(input logic [1:0] mode, input int addr, input logic [FW-1:0] p);
    host_xfer(mode, AW'(addr), p, '0, '0);
    if (mode == 2'b00 && addr < NN)   m_fea[addr]   = p;
    if (mode == 2'b01 && addr < NN)   m_thr[addr]   = p;
    if (mode == 2'b10 && addr < 2*NN) m_child[addr] = p;
  endtask

  // Waits for out_valid (counting cycles after accept), captures, then completes the handshake.
  task automatic get_result(output int lat, output logic [IDW-1:0] id,
                            output logic c1, output logic [2:0] c3, output logic err);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    if (lat >= 100) begin
      cmp_count++; fail_count++;
      $display("FAIL result_timeout: out_valid=%b after 100 cycles", out_valid);
    end
    id = out_id; c1 = out_class; c3 = out_class3; err = out_err;
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic program_root();
    write_word(2'b00, 0, 8'd3);
    write_word(2'b01, 0, 8'h80);
    write_word(2'b10, 0, 8'h81);
    write_word(2'b10, 1, 8'h80);
  endtask

  task automatic test_reset();
    cmp_count++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_id !== '0 ||
        out_class !== '0 || out_err !== 1'b0) begin
      fail_count++;
      $display("FAIL reset_state: rdy=%b vld=%b id=%0d cls=%0d err=%b required 1 0 0 0 0",
               in_ready, out_valid, out_id, out_class, out_err);
    end
  endtask

  task automatic test_root();
    int lat; logic [IDW-1:0] id; logic c1, e; logic [2:0] c3;
    logic [DW-1:0] d;
    program_root();
    d = '0; d[3*FW +: FW] = 8'h80;
    host_xfer(2'b11, '0, '0, d, 12'd5);
    get_result(lat, id, c1, c3, e);
    cmp_count++;
    if (lat !== 2 || id !== 12'd5 || c1 !== 1'b1 || e !== 1'b0 || c3 !== 3'd1) begin
      fail_count++;
      $display("FAIL root_le: lat=%0d id=%0d cls=%0d cls3=%0d err=%b required 2 5 1 1 0",
               lat, id, c1, c3, e);
    end
    d[3*FW +: FW] = 8'h81;
    host_xfer(2'b11, '0, '0, d, 12'd6);
    get_result(lat, id, c1, c3, e);
    cmp_count++;
    if (lat !== 2 || id !== 12'd6 || c1 !== 1'b0 || e !== 1'b0 || c3 !== 3'd0) begin
      fail_count++;
      $display("FAIL root_gt: lat=%0d id=%0d cls=%0d cls3=%0d err=%b required 2 6 0 0 0",
               lat, id, c1, c3, e);
    end
  endtask

  task automatic test_class3();
    int lat; logic [IDW-1:0] id; logic c1, e; logic [2:0] c3;
    logic [DW-1:0] d;
    write_word(2'b10, 0, 8'h86);
    d = '0; d[3*FW +: FW] = 8'h10;
    host_xfer(2'b11, '0, '0, d, 12'd7);
    get_result(lat, id, c1, c3, e);
    cmp_count++;
    if (c3 !== 3'd6 || c1 !== 1'b0 || e !== 1'b0 || lat !== 2) begin
      fail_count++;
      $display("FAIL class3_leaf: cls3=%0d cls1=%0d err=%b lat=%0d required 6 0 0 2",
               c3, c1, e, lat);
    end
  endtask

  task automatic test_bad_fea();
    int lat; logic [IDW-1:0] id; logic c1, e; logic [2:0] c3;
    write_word(2'b00, 0, 8'd8);
    host_xfer(2'b11, '0, '0, {DW{1'b1}}, 12'd9);
    get_result(lat, id, c1, c3, e);
    cmp_count++;
    if (e !== 1'b1 || c1 !== 1'b0 || lat !== 2 || id !== 12'd9) begin
      fail_count++;
      $display("FAIL bad_feature: err=%b cls=%0d lat=%0d id=%0d required 1 0 2 9", e, c1, lat, id);
    end
    write_word(2'b00, 0, 8'd3);
  endtask

  task automatic test_bad_child();
    int lat; logic [IDW-1:0] id; logic c1, e; logic [2:0] c3;
    write_word(2'b10, 0, 8'h0C);
    host_xfer(2'b11, '0, '0, '0, 12'd10);
    get_result(lat, id, c1, c3, e);
    cmp_count++;
    if (e !== 1'b1 || c1 !== 1'b0 || lat !== 2) begin
      fail_count++;
      $display("FAIL bad_child_index: err=%b cls=%0d lat=%0d required 1 0 2", e, c1, lat);
    end
  endtask

  task automatic test_loop();
    int lat; logic [IDW-1:0] id; logic c1, e; logic [2:0] c3;
    write_word(2'b00, 0, 8'd0);
    write_word(2'b01, 0, 8'd0);
    write_word(2'b10, 0, 8'h00);
    write_word(2'b10, 1, 8'h00);
    host_xfer(2'b11, '0, '0, 64'h0123_4567_89AB_CDEF, 12'd11);
    get_result(lat, id, c1, c3, e);
    cmp_count++;
    if (e !== 1'b1 || c1 !== 1'b0 || lat !== MD + 1 || id !== 12'd11) begin
      fail_count++;
      $display("FAIL depth_guard: err=%b cls=%0d lat=%0d id=%0d required 1 0 %0d 11",
               e, c1, lat, id, MD + 1);
    end
  endtask

  task automatic test_backpressure();
    int lat, extra; logic [IDW-1:0] id; logic c1, e; logic [2:0] c3;
    logic [DW-1:0] d;
    program_root();
    d = '0; d[3*FW +: FW] = 8'h20;
    out_ready = 1'b0;
    host_xfer(2'b11, '0, '0, d, 12'hABC);
    get_result(lat, id, c1, c3, e);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cmp_count++;
      if (out_valid !== 1'b1 || out_id !== 12'hABC || out_class !== 1'b1 ||
          out_err !== 1'b0 || in_ready !== 1'b0) begin
        fail_count++;
        $display("FAIL backpressure_hold[%0d]: vld=%b id=%h cls=%0d err=%b rdy=%b required 1 abc 1 0 0",
                 i, out_valid, out_id, out_class, out_err, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    cmp_count++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fail_count++;
      $display("FAIL backpressure_release: vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    extra = 0;
    repeat (5) begin @(posedge clk); #1; if (out_valid === 1'b1) extra++; end
    cmp_count++;
    if (extra != 0) begin
      fail_count++;
      $display("FAIL backpressure_single: extra results=%0d required 0", extra);
    end
  endtask

  task automatic test_reset_mid_walk();
    int lat, seen; logic [IDW-1:0] id; logic c1, e; logic [2:0] c3;
    write_word(2'b10, 0, 8'h00);
    write_word(2'b10, 1, 8'h00);
    host_xfer(2'b11, '0, '0, '0, 12'd77);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < NN; i++) begin m_fea[i] = '0; m_thr[i] = '0; end
    for (int i = 0; i < 2*NN; i++) m_child[i] = '0;
    cmp_count++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fail_count++;
      $display("FAIL reset_abort: vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (out_valid === 1'b1) seen++; end
    cmp_count++;
    if (seen != 0) begin
      fail_count++;
      $display("FAIL reset_no_output: results=%0d required 0", seen);
    end
    host_xfer(2'b11, '0, '0, 64'hFFFF_0000_FFFF_0000, 12'd78);
    get_result(lat, id, c1, c3, e);
    cmp_count++;
    if (e !== 1'b1 || c1 !== 1'b0 || lat !== MD + 1 || id !== 12'd78) begin
      fail_count++;
      $display("FAIL zero_tables: err=%b cls=%0d lat=%0d id=%0d required 1 0 %0d 78",
               e, c1, lat, id, MD + 1);
    end
  endtask

  task automatic test_random(input int trees, input int samples, input bit acyclic);
    int lat, k, lo; logic [IDW-1:0] id, eid; logic c1, e, xe; logic [2:0] c3, xc;
    logic [DW-1:0] d;
    logic [FW-1:0] c;
    for (int t = 0; t < trees; t++) begin
      for (int n = 0; n < NN; n++) begin
        write_word(2'b00, n, ($urandom_range(0, 19) == 0) ? FW'($urandom_range(8, 255))
                                                          : FW'($urandom_range(0, 7)));
        write_word(2'b01, n, FW'($urandom));
        for (int s = 0; s < 2; s++) begin
          if (n == NN - 1 || $urandom_range(0, 2) == 0) begin
            c = 8'h80 | FW'($urandom_range(0, 127));
          end else begin
            lo = acyclic ? n + 1 : 0;
            c = {1'b0, 3'($urandom), 4'($urandom_range(lo, NN - 1))};
            if ($urandom_range(0, 29) == 0) c[3:0] = 4'($urandom_range(NN, 15));
          end
          write_word(2'b10, 2*n + s, c);
        end
      end
      // Out-of-range writes that must leave every table untouched.
      write_word(2'b00, $urandom_range(NN, 31), FW'($urandom));
      write_word(2'b01, $urandom_range(NN, 31), FW'($urandom));
      write_word(2'b10, $urandom_range(2*NN, 31), FW'($urandom));
      for (int i = 0; i < samples; i++) begin
        d = {$urandom, $urandom};
        eid = IDW'($urandom);
        model(d, xc, xe, k);
        host_xfer(2'b11, '0, '0, d, eid);
        get_result(lat, id, c1, c3, e);
        cmp_count++;
        if (id !== eid || c1 !== xc[0] || c3 !== xc || e !== xe || lat !== k + 1) begin
          fail_count++;
          $display("FAIL random_t%0d_s%0d: id=%h cls=%0d cls3=%0d err=%b lat=%0d required %h %0d %0d %b %0d",
                   t, i, id, c1, c3, e, lat, eid, xc[0], xc, xe, k + 1);
        end
      end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_root();
    test_class3();
    test_bad_fea();
    test_bad_child();
    test_loop();
    test_backpressure();
    test_reset_mid_walk();
    test_random(3, 100, 1'b1);
    test_random(2, 60, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule

`default_nettype wire
